// File: rtl/apb_master_if.sv
`default_nettype none
// ============================================================================
// Module   : apb_master_if
// Brief    : Command/response channel and APB bus bundle for apb_master.
// Revision : 1.0  initial release
// ============================================================================
interface apb_master_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
               PRDATA, PREADY, PSLVERR,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
               PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
               PRDATA, PREADY, PSLVERR,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
               PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface
`default_nettype wire

// File: rtl/apb_master.sv
`default_nettype none
// ============================================================================
// Module   : apb_master
// Brief    : Single-outstanding APB requester with valid/ready command and
//            response channels and a wait-state timeout.
// Revision : 1.0  initial release
// ============================================================================
module apb_master #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 16
) (
    input  wire logic       PCLK,
    input  wire logic       PRESET,
    apb_master_if.master    bus
);
    localparam logic [7:0] C_TIMEOUT    = 8'(TIMEOUT);
    localparam logic       C_TIMEOUT_EN = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_accept;
    logic              w_done;
    logic              w_abort;
    logic [7:0]        r_wait_cnt;
    logic [7:0]        w_wait_inc;
    logic              r_pwrite;
    logic [ADDR_W-1:0] r_paddr;
    logic [DATA_W-1:0] r_pwdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;
    logic              r_timeout;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_done      = 1'b0;
        w_abort     = 1'b0;
        w_wait_inc  = r_wait_cnt + 8'd1;
        case (r_state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = SETUP;
                end
            end
            SETUP: begin
                w_state_nxt = ACCESS;
            end
            ACCESS: begin
                // PREADY takes priority over an abort landing on the same edge
                if (bus.PREADY) begin
                    w_done      = 1'b1;
                    w_state_nxt = RESP;
                end else if (C_TIMEOUT_EN && (w_wait_inc == C_TIMEOUT)) begin
                    w_abort     = 1'b1;
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_pwrite   <= 1'b0;
            r_paddr    <= '0;
            r_pwdata   <= '0;
            r_wait_cnt <= '0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_pwrite   <= bus.cmd_write;
                r_paddr    <= bus.cmd_addr;
                r_pwdata   <= bus.cmd_wdata;
                r_wait_cnt <= '0;
            end else if ((r_state == ACCESS) && !bus.PREADY) begin
                r_wait_cnt <= w_wait_inc;
            end

            if (w_done) begin
                r_rdata   <= r_pwrite ? '0 : bus.PRDATA;
                r_err     <= bus.PSLVERR;
                r_timeout <= 1'b0;
            end else if (w_abort) begin
                r_rdata   <= '0;
                r_err     <= 1'b1;
                r_timeout <= 1'b1;
            end
        end
    end

    // Strobes decode straight from state so reset drops them without a clock
    assign bus.cmd_ready   = (r_state == IDLE);
    assign bus.PSEL        = (r_state == SETUP) || (r_state == ACCESS);
    assign bus.PENABLE     = (r_state == ACCESS);
    assign bus.rsp_valid   = (r_state == RESP);
    assign bus.PWRITE      = r_pwrite;
    assign bus.PADDR       = r_paddr;
    assign bus.PWDATA      = r_pwdata;
    assign bus.rsp_rdata   = r_rdata;
    assign bus.rsp_err     = r_err;
    assign bus.rsp_timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_apb_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_master
// Brief    : Scoreboard bench for apb_master with a reactive APB slave model.
// Revision : 1.0  initial release
// ============================================================================
module tb_apb_master;
    localparam int AW = 8;
    localparam int DW = 16;
    localparam int TO = 4;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            nwait;
        logic          slverr;
        logic [DW-1:0] prdata;
    } plan_t;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        logic          to;
        int            cyc;
        int            hold;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   last_acc = 0;

    plan_t plan_q[$];
    exp_t  exp_q[$];

    apb_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    apb_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .PCLK   (clk),
        .PRESET (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Expected response from the transfer's wait-state count alone.
    // Cycle numbers are sampled at negedges; the SETUP cycle reads as acc.
    function automatic exp_t model(input plan_t p, input int acc, input int hold);
        exp_t e;
        if (TO != 0 && p.nwait >= TO) begin
            e.rdata = '0;
            e.err   = 1'b1;
            e.to    = 1'b1;
            e.cyc   = acc + 1 + TO;
        end else begin
            e.rdata = p.wr ? '0 : p.prdata;
            e.err   = p.slverr;
            e.to    = 1'b0;
            e.cyc   = acc + 2 + p.nwait;
        end
        e.hold = hold;
        return e;
    endfunction

    // APB slave: answers from plan_q and checks the bus protocol
    initial begin
        plan_t cur;
        int    acc_n = 0;
        logic  prev_psel = 1'b0;
        cur = '{1'b0, '0, '0, 0, 1'b0, '0};
        bus.PREADY  = 1'b0;
        bus.PRDATA  = '0;
        bus.PSLVERR = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.PSEL && !bus.PENABLE) begin
                chk("psel_gap_between_transfers", 32'(prev_psel), 32'd0);
                chk("setup_has_cmd", 32'(plan_q.size() != 0), 32'd1);
                if (plan_q.size() != 0) cur = plan_q.pop_front();
                acc_n = 0;
                chk("setup_paddr", 32'(bus.PADDR), 32'(cur.addr));
                chk("setup_pwrite", 32'(bus.PWRITE), 32'(cur.wr));
                if (cur.wr) chk("setup_pwdata", 32'(bus.PWDATA), 32'(cur.wdata));
                bus.PREADY  = 1'($urandom);
                bus.PRDATA  = DW'($urandom);
                bus.PSLVERR = 1'($urandom);
            end else if (bus.PSEL && bus.PENABLE) begin
                chk("penable_after_psel", 32'(prev_psel), 32'd1);
                chk("access_paddr", 32'(bus.PADDR), 32'(cur.addr));
                chk("access_pwrite", 32'(bus.PWRITE), 32'(cur.wr));
                if (cur.wr) chk("access_pwdata", 32'(bus.PWDATA), 32'(cur.wdata));
                acc_n++;
                if (acc_n > cur.nwait) begin
                    bus.PREADY  = 1'b1;
                    bus.PRDATA  = cur.prdata;
                    bus.PSLVERR = cur.slverr;
                end else begin
                    bus.PREADY  = 1'b0;
                    bus.PRDATA  = DW'($urandom);
                    bus.PSLVERR = 1'($urandom);
                end
            end else begin
                chk("penable_without_psel", 32'(bus.PENABLE), 32'd0);
                bus.PREADY  = 1'($urandom);
                bus.PRDATA  = DW'($urandom);
                bus.PSLVERR = 1'($urandom);
            end
            prev_psel = bus.PSEL;
        end
    end

    // Response monitor: pops the scoreboard and drives rsp_ready
    initial begin
        exp_t cur_e;
        bit   in_rsp = 1'b0;
        int   held = 0;
        cur_e = '{'0, 1'b0, 1'b0, 0, 0};
        bus.rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.cmd_ready)
                chk("cmd_ready_only_idle", 32'({bus.PSEL, bus.rsp_valid}), 32'd0);
            if (bus.rsp_valid) begin
                if (!in_rsp) begin
                    chk("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) cur_e = exp_q.pop_front();
                    in_rsp = 1'b1;
                    held   = 0;
                    chk("rsp_cycle", 32'(cyc), 32'(cur_e.cyc));
                end
                chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(cur_e.rdata));
                chk("rsp_err", 32'(bus.rsp_err), 32'(cur_e.err));
                chk("rsp_timeout", 32'(bus.rsp_timeout), 32'(cur_e.to));
                if (held >= cur_e.hold) begin
                    bus.rsp_ready = 1'b1;
                    in_rsp        = 1'b0;
                end else begin
                    bus.rsp_ready = 1'b0;
                    held++;
                end
            end else begin
                in_rsp        = 1'b0;
                bus.rsp_ready = 1'($urandom);
            end
        end
    end

    // Leaves cmd_valid high so consecutive calls form a back-to-back stream
    task automatic do_txn(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input int nwait, input logic slverr, input logic [DW-1:0] prdata,
                          input int hold, input bit no_rsp);
        plan_t p;
        bit    ok = 1'b0;
        p.wr = wr; p.addr = addr; p.wdata = wdata;
        p.nwait = nwait; p.slverr = slverr; p.prdata = prdata;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
        for (int i = 0; i < 200; i++) begin
            if (bus.cmd_ready) begin
                last_acc = cyc + 1;
                plan_q.push_back(p);
                if (!no_rsp) exp_q.push_back(model(p, last_acc, hold));
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("cmd_accepted", 32'(ok), 32'd1);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bus.cmd_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int a1;
        bit seen;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rst_psel", 32'(bus.PSEL), 32'd0);
        chk("rst_penable", 32'(bus.PENABLE), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_fields", 32'({bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout}), 32'd0);
        chk("rst_apb_fields", 32'({bus.PWRITE, bus.PADDR, bus.PWDATA}), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Reset while mid-ACCESS: strobes fall at once, no response follows
        do_txn(1'b0, 8'h55, 16'h0, 20, 1'b0, 16'h0, 0, 1'b1);
        bus.cmd_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (bus.PSEL && bus.PENABLE) seen = 1'b1;
            else @(negedge clk);
        end
        chk("reach_access", 32'(seen), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_psel", 32'(bus.PSEL), 32'd0);
        chk("async_rst_penable", 32'(bus.PENABLE), 32'd0);
        chk("async_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("post_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        repeat (8) @(negedge clk);

        do_txn(1'b1, 8'h12, 16'hBEEF, 0, 1'b0, 16'h0, 0, 1'b0);    idle(2);
        do_txn(1'b0, 8'h34, 16'h0, 3, 1'b0, 16'hA5C3, 0, 1'b0);    idle(2);
        do_txn(1'b0, 8'h56, 16'h0, 0, 1'b1, 16'h1234, 4, 1'b0);    idle(2);
        do_txn(1'b0, 8'h78, 16'h0, 50, 1'b0, 16'h0, 1, 1'b0);      idle(2);
        do_txn(1'b0, 8'h79, 16'h0, TO - 1, 1'b0, 16'h7E57, 0, 1'b0); idle(2);
        do_txn(1'b1, 8'h7A, 16'h1111, TO, 1'b1, 16'h0, 0, 1'b0);   idle(2);

        // Zero-wait stream: SETUP, ACCESS, RESP, then one IDLE cycle to accept
        do_txn(1'b1, 8'hA0, 16'hCAFE, 0, 1'b0, 16'h0, 0, 1'b0);
        a1 = last_acc;
        do_txn(1'b0, 8'hA1, 16'h0, 0, 1'b0, 16'h5A5A, 0, 1'b0);
        chk("b2b_spacing", 32'(last_acc - a1), 32'd4);
        do_txn(1'b1, 8'hA2, 16'hD00D, 1, 1'b0, 16'h0, 0, 1'b0);
        idle(3);

        for (int k = 0; k < 60; k++) begin
            do_txn(1'($urandom), AW'($urandom), DW'($urandom), $urandom_range(0, 6),
                   1'($urandom), DW'($urandom), $urandom_range(0, 3), 1'b0);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 3));
        end
        idle(0);

        for (int i = 0; i < 300 && (exp_q.size() != 0 || bus.rsp_valid); i++) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got %0d cycles, expected completion", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
